// File: rtl/playback_checker.sv
// Vector playback checker: buffers stimulus/expected/mask vectors, drives the
// stimulus to a DUT and compares its response LATENCY cycles later under a mask.
module playback_checker #(
    parameter int IN_WIDTH  = 43,
    parameter int OUT_WIDTH = 39,
    parameter int DEPTH     = 16,
    parameter int LATENCY   = 1,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop_on_fail,
    input  logic                 vec_valid,
    output logic                 vec_ready,
    input  logic [IN_WIDTH-1:0]  vec_stim,
    input  logic [OUT_WIDTH-1:0] vec_exp,
    input  logic [OUT_WIDTH-1:0] vec_mask,
    input  logic                 vec_last,
    output logic [IN_WIDTH-1:0]  dut_in,
    input  logic [OUT_WIDTH-1:0] dut_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_WIDTH-1:0] mismatch_cnt,
    output logic [CNT_WIDTH-1:0] vec_idx,
    output logic [CNT_WIDTH-1:0] first_fail_idx,
    output logic [OUT_WIDTH-1:0] first_fail_bits,
    output logic [CNT_WIDTH-1:0] underrun_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = IN_WIDTH + 2 * OUT_WIDTH + 1;
    localparam int DW = $clog2(LATENCY + 1);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

    state_t               state;
    logic                 stop_latch;
    logic [DW-1:0]        drain_cnt;

    logic [EW-1:0]        fifo_mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          fifo_cnt;
    logic                 fifo_wr;
    logic                 fifo_rd;
    logic                 fifo_empty;
    logic                 flush;
    logic [IN_WIDTH-1:0]  rd_stim;
    logic [OUT_WIDTH-1:0] rd_exp;
    logic [OUT_WIDTH-1:0] rd_mask;
    logic                 rd_last;

    logic [OUT_WIDTH-1:0] pl_exp  [LATENCY];
    logic [OUT_WIDTH-1:0] pl_mask [LATENCY];
    logic [CNT_WIDTH-1:0] pl_idx  [LATENCY];
    logic [LATENCY-1:0]   pl_vld;
    logic [OUT_WIDTH-1:0] tail_diff;
    logic                 tail_fail;
    logic                 stop_now;

    assign vec_ready  = fifo_cnt != FULL_CNT;
    assign fifo_empty = fifo_cnt == '0;
    assign fifo_wr    = vec_valid && vec_ready;
    // Restarting from DONE discards whatever a stop_on_fail halt left behind.
    assign flush      = start && (state == ST_DONE);
    assign {rd_stim, rd_exp, rd_mask, rd_last} = fifo_mem[rd_ptr];

    assign tail_diff = (pl_exp[LATENCY-1] ^ dut_out) & pl_mask[LATENCY-1];
    assign tail_fail = pl_vld[LATENCY-1] && (tail_diff != '0);
    assign stop_now  = stop_latch && tail_fail;
    assign fifo_rd   = (state == ST_RUN) && !fifo_empty && !stop_now;
    assign pass      = done && (mismatch_cnt == '0);

    always_ff @(posedge clk) begin
        if (fifo_wr)
            fifo_mem[flush ? '0 : wr_ptr] <= {vec_stim, vec_exp, vec_mask, vec_last};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (flush) begin
            rd_ptr   <= '0;
            wr_ptr   <= fifo_wr ? AW'(1) : '0;
            fifo_cnt <= fifo_wr ? (AW + 1)'(1) : '0;
        end else begin
            if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
            if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
            if (fifo_wr && !fifo_rd)
                fifo_cnt <= fifo_cnt + 1'b1;
            else if (!fifo_wr && fifo_rd)
                fifo_cnt <= fifo_cnt - 1'b1;
        end
    end

    // Payload stages need no reset; only the valid bits qualify a compare.
    always_ff @(posedge clk) begin
        pl_exp[0]  <= rd_exp;
        pl_mask[0] <= rd_mask;
        pl_idx[0]  <= vec_idx;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            pl_exp[i]  <= pl_exp[i-1];
            pl_mask[i] <= pl_mask[i-1];
            pl_idx[i]  <= pl_idx[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            stop_latch      <= 1'b0;
            drain_cnt       <= '0;
            dut_in          <= '0;
            mismatch_cnt    <= '0;
            vec_idx         <= '0;
            first_fail_idx  <= '0;
            first_fail_bits <= '0;
            underrun_cnt    <= '0;
            pl_vld          <= '0;
        end else begin
            pl_vld[0] <= fifo_rd;
            for (int unsigned i = 1; i < LATENCY; i++)
                pl_vld[i] <= pl_vld[i-1];

            if (tail_fail) begin
                if (mismatch_cnt == '0) begin
                    first_fail_idx  <= pl_idx[LATENCY-1];
                    first_fail_bits <= tail_diff;
                end
                if (mismatch_cnt != '1)
                    mismatch_cnt <= mismatch_cnt + 1'b1;
            end

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state           <= ST_RUN;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        stop_latch      <= stop_on_fail;
                        drain_cnt       <= '0;
                        mismatch_cnt    <= '0;
                        vec_idx         <= '0;
                        first_fail_idx  <= '0;
                        first_fail_bits <= '0;
                        underrun_cnt    <= '0;
                    end
                end
                ST_RUN: begin
                    if (stop_now) begin
                        state <= ST_DRAIN;
                    end else if (fifo_rd) begin
                        dut_in  <= rd_stim;
                        vec_idx <= vec_idx + 1'b1;
                        if (rd_last) state <= ST_DRAIN;
                    end else if (underrun_cnt != '1) begin
                        underrun_cnt <= underrun_cnt + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == DW'(LATENCY)) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_playback_checker.sv
// Directed bench for playback_checker: a LATENCY=1 instance with a looped-back
// DUT and a LATENCY=3 instance behind a two-register DUT model.
module tb_playback_checker;
    localparam int IW = 43;
    localparam int OW = 39;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          stop_on_fail = 1'b0;
    logic          vec_valid = 1'b0;
    logic          vec_last = 1'b0;
    logic          sel3 = 1'b0;
    logic [IW-1:0] vec_stim = '0;
    logic [OW-1:0] vec_exp = '0;
    logic [OW-1:0] vec_mask = '0;

    logic          start1, start3, valid1, valid3;
    logic          ready1, busy1, done1, pass1;
    logic          ready3, busy3, done3, pass3;
    logic [IW-1:0] dut_in1, dut_in3;
    logic [OW-1:0] dut_out1, dut_out3, ffb1, ffb3, d3_q1, d3_q2;
    logic [CW-1:0] mis1, idx1, ffi1, und1;
    logic [CW-1:0] mis3, idx3, ffi3, und3;

    int n_checks = 0;
    int n_fail   = 0;

    assign start1 = start & ~sel3;
    assign start3 = start & sel3;
    assign valid1 = vec_valid & ~sel3;
    assign valid3 = vec_valid & sel3;

    assign dut_out1 = dut_in1[OW-1:0];
    always_ff @(posedge clk) begin
        d3_q1 <= dut_in3[OW-1:0];
        d3_q2 <= d3_q1;
    end
    assign dut_out3 = d3_q2;

    always #5 clk = ~clk;

    playback_checker #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .DEPTH(16), .LATENCY(1), .CNT_WIDTH(CW)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .stop_on_fail(stop_on_fail),
        .vec_valid(valid1), .vec_ready(ready1), .vec_stim(vec_stim), .vec_exp(vec_exp),
        .vec_mask(vec_mask), .vec_last(vec_last), .dut_in(dut_in1), .dut_out(dut_out1),
        .busy(busy1), .done(done1), .pass(pass1), .mismatch_cnt(mis1), .vec_idx(idx1),
        .first_fail_idx(ffi1), .first_fail_bits(ffb1), .underrun_cnt(und1)
    );

    playback_checker #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .DEPTH(16), .LATENCY(3), .CNT_WIDTH(CW)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .stop_on_fail(stop_on_fail),
        .vec_valid(valid3), .vec_ready(ready3), .vec_stim(vec_stim), .vec_exp(vec_exp),
        .vec_mask(vec_mask), .vec_last(vec_last), .dut_in(dut_in3), .dut_out(dut_out3),
        .busy(busy3), .done(done3), .pass(pass3), .mismatch_cnt(mis3), .vec_idx(idx3),
        .first_fail_idx(ffi3), .first_fail_bits(ffb3), .underrun_cnt(und3)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    function automatic logic [IW-1:0] stim_of(input int k);
        logic [63:0] v;
        v = 64'h9E37_79B9_7F4A_7C15 * 64'(k + 1);
        return v[IW-1:0];
    endfunction

    task automatic push_vec(input int k, input logic last, input logic bad, input logic mask5_off);
        logic [IW-1:0] s;
        s         = stim_of(k);
        vec_stim  = s;
        vec_exp   = s[OW-1:0] ^ (bad ? 39'h20 : 39'h0);
        vec_mask  = mask5_off ? ~39'h20 : '1;
        vec_last  = last;
        vec_valid = 1'b1;
        tick();
        vec_valid = 1'b0;
        vec_last  = 1'b0;
    endtask

    task automatic pulse_start(input logic sof);
        stop_on_fail = sof;
        start = 1'b1;
        tick();
        start = 1'b0;
        stop_on_fail = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (((sel3 ? done3 : done1) == 1'b0) && n < 100) begin
            tick();
            n++;
        end
        check(tag, sel3 ? done3 : done1, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        rst = 1'b0;
        check("rst_ready", ready1, 1);
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_pass", pass1, 0);
        check("rst_mismatch", mis1, 0);
        check("rst_vec_idx", idx1, 0);
        check("rst_dut_in", dut_in1, 0);
        check("rst_underrun", und1, 0);
        check("rst_ff_idx", ffi1, 0);
        check("rst_ff_bits", ffb1, 0);
        check("rst_ready3", ready3, 1);

        // Clean pass, preloaded: done exactly 10 cycles after start.
        sel3 = 1'b0;
        do_reset();
        for (int k = 0; k < 8; k++) push_vec(k, k == 7, 1'b0, 1'b0);
        pulse_start(1'b0);
        check("clean_dut_in_hold", dut_in1, 0);
        tick();
        check("clean_first_dut_in", dut_in1, stim_of(0));
        check("clean_busy", busy1, 1);
        for (int c = 2; c <= 9; c++) tick();
        check("clean_not_done_9", done1, 0);
        tick();
        check("clean_done_10", done1, 1);
        check("clean_pass", pass1, 1);
        check("clean_vec_idx", idx1, 8);
        check("clean_mismatch", mis1, 0);
        check("clean_busy_off", busy1, 0);

        // Vector 3 carries a wrong exp bit 5, masked off.
        do_reset();
        for (int k = 0; k < 8; k++) push_vec(k, k == 7, k == 3, k == 3);
        pulse_start(1'b0);
        wait_done("mask_off_done");
        check("mask_off_pass", pass1, 1);
        check("mask_off_mismatch", mis1, 0);

        // Same fault, compared.
        do_reset();
        for (int k = 0; k < 8; k++) push_vec(k, k == 7, k == 3, 1'b0);
        pulse_start(1'b0);
        wait_done("mask_on_done");
        check("mask_on_pass", pass1, 0);
        check("mask_on_mismatch", mis1, 1);
        check("mask_on_ff_idx", ffi1, 3);
        check("mask_on_ff_bits", ffb1, 39'h20);
        check("mask_on_vec_idx", idx1, 8);

        // Stop on fail, LATENCY=3, faults at 2 and 5.
        sel3 = 1'b1;
        do_reset();
        for (int k = 0; k < 10; k++) push_vec(k, k == 9, (k == 2) || (k == 5), 1'b0);
        pulse_start(1'b1);
        wait_done("stop_done");
        check("stop_vec_idx", idx3, 5);
        check("stop_mismatch", mis3, 1);
        check("stop_ff_idx", ffi3, 2);
        check("stop_ff_bits", ffb3, 39'h20);
        check("stop_pass", pass3, 0);
        check("stop_fifo_left", 64'(u_dut3.fifo_cnt), 5);

        // Underrun: FIFO written at E2, E5, E8, E11 after the start edge E0.
        sel3 = 1'b0;
        do_reset();
        pulse_start(1'b0);
        tick();
        for (int k = 0; k < 4; k++) begin
            push_vec(k, k == 3, 1'b0, 1'b0);
            tick();
            tick();
        end
        wait_done("under_done");
        check("under_count", und1, 8);
        check("under_pass", pass1, 1);
        check("under_mismatch", mis1, 0);
        check("under_vec_idx", idx1, 4);

        // Full FIFO: 16 writes, offered writes while full are refused.
        do_reset();
        for (int k = 0; k < 16; k++) begin
            check("full_ready_before_write", ready1, 1);
            push_vec(k, k == 15, 1'b0, 1'b0);
        end
        check("full_ready_low", ready1, 0);
        vec_stim  = stim_of(99);
        vec_exp   = '0;
        vec_mask  = '1;
        vec_last  = 1'b1;
        vec_valid = 1'b1;
        tick();
        check("full_hold_ready_1", ready1, 0);
        tick();
        check("full_hold_ready_2", ready1, 0);
        vec_valid = 1'b0;
        vec_last  = 1'b0;
        pulse_start(1'b0);
        tick();
        check("full_ready_after_pop", ready1, 1);
        wait_done("full_done");
        check("full_pass", pass1, 1);
        check("full_vec_idx", idx1, 16);

        // Asynchronous reset mid-run after three failures.
        do_reset();
        for (int k = 0; k < 8; k++) push_vec(k, 1'b0, k < 3, 1'b0);
        pulse_start(1'b0);
        for (int c = 1; c <= 4; c++) tick();
        check("midrst_pre_mismatch", mis1, 3);
        check("midrst_pre_busy", busy1, 1);
        check("midrst_pre_vec_idx", idx1, 4);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", busy1, 0);
        check("midrst_done", done1, 0);
        check("midrst_pass", pass1, 0);
        check("midrst_mismatch", mis1, 0);
        check("midrst_vec_idx", idx1, 0);
        check("midrst_dut_in", dut_in1, 0);
        check("midrst_underrun", und1, 0);
        check("midrst_ff_idx", ffi1, 0);
        check("midrst_ff_bits", ffb1, 0);
        check("midrst_ready", ready1, 1);
        tick();
        rst = 1'b0;
        tick();
        push_vec(20, 1'b0, 1'b0, 1'b0);
        push_vec(21, 1'b1, 1'b0, 1'b0);
        pulse_start(1'b0);
        wait_done("midrst_rerun_done");
        check("midrst_rerun_pass", pass1, 1);
        check("midrst_rerun_vec_idx", idx1, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
